spi_read_ctrl: RTL
==================

Name: spi_read_ctrl

Overview:
Sequencer for an SPI read frame (mode 0, CPOL=0/CPHA=0, MSB first). It generates cs_o and sclk_o, samples miso_i, and drives the external bit counter through a 2-bit opcode (00 clear, 01 hold, 10 increment, 11 clear). It uses the counter value returned on cnt_i to end the frame. It sits between the host-side start/done handshake and the pins of an ADC or sensor read interface.

Parameters:
Width, 6, width of the external bit counter (cnt_i); Bits must be less than 2^Width
Bits, 16, number of bits per frame (1..2^Width-1)
HalfDiv, 2, sclk half-period in clk_i cycles (>=1)

Ports:
clk_i  input  1  system clock, all state on rising edge
rst_i  input  1  asynchronous reset, active-high
start_i  input  1  frame request, sampled only in IDLE
miso_i  input  1  serial data from slave
cnt_i  input  Width  current value of the external bit counter
opc_o  output  2  opcode to the bit counter
cs_o  output  1  chip select, active-low
sclk_o  output  1  serial clock, idle low
data_o  output  Bits  last completed frame, MSB = first bit received
busy_o  output  1  high from SETUP through the last LOW cycle
done_o  output  1  one-cycle pulse when data_o is updated

Behaviour:
- Interface: one clock, clk_i; asynchronous active-high reset, rst_i.
- Reset values (applied immediately, including mid-frame): state IDLE, cs_o=1, sclk_o=0, opc_o=00, data_o=0, busy_o=0, done_o=0, shift register 0, half-period timer 0.
- All outputs are registered. Outputs are a function of the current state and timer only.
- States: IDLE, SETUP, HIGH, LOW, DONE.
- IDLE:
  - cs_o=1, sclk_o=0, opc_o=00 (keeps the counter cleared).
  - start_i=1 -> SETUP.
- SETUP:
  - cs_o=0, sclk_o=0, opc_o=01, busy_o=1.
  - Lasts HalfDiv cycles (CS setup), then -> HIGH.
- HIGH:
  - sclk_o=1, cs_o=0.
  - First cycle of HIGH: shift register <= {shift[Bits-2:0], miso_i} and opc_o=10 (exactly one increment per sclk rising edge).
  - Remaining cycles: opc_o=01.
  - Lasts HalfDiv cycles, then -> LOW.
- LOW:
  - sclk_o=0, cs_o=0, opc_o=01.
  - Lasts HalfDiv cycles.
  - On the last cycle: cnt_i == Bits -> DONE; otherwise -> HIGH.
  - The counter has a 1-cycle update latency, which is always satisfied because HalfDiv>=1.
- DONE (1 cycle):
  - cs_o=1, sclk_o=0, opc_o=00 (clear), busy_o=0, done_o=1.
  - data_o <= shift register.
  - -> IDLE.
- Frame timing: cs_o is low for HalfDiv*(1+2*Bits) cycles, and there are exactly Bits sclk pulses.
- Start-to-done latency: done_o is high HalfDiv*(1+2*Bits)+1 cycles after the cycle in which start_i is sampled in IDLE.
- start_i outside IDLE is ignored; there is no queueing.
- start_i held high gives back-to-back frames with exactly one IDLE cycle between DONE and the next SETUP.
- data_o holds its value between DONE pulses and is not disturbed by a frame in progress.
- Reset asserted mid-frame: frame abandoned, cs_o rises asynchronously, no done_o pulse, data_o returns to 0. The counter shares rst_i, and the next frame starts from count 0.
- cnt_i is used only for the Bits comparison, as an unsigned equality test on the full Width bits.

Test Plan:
- Reset: assert rst_i mid-HIGH of a frame (Bits=16, HalfDiv=2) -> cs_o=1, sclk_o=0, opc_o=00, busy_o=0 within the reset cycle; no done_o.
- Single frame: Bits=16, HalfDiv=2, slave drives 0xA5C3 MSB first, changing on sclk falling edges -> data_o=0xA5C3 and done_o high for 1 cycle.
  - done_o arrives 67 cycles after start_i is sampled.
  - cs_o is low for exactly 66 cycles, with 16 sclk pulses each 2 high / 2 low.
- Opcode sequence: monitor opc_o over one frame.
  - Exactly 16 cycles with opc_o=10, each on the first HIGH cycle.
  - opc_o=00 in IDLE and DONE, 01 elsewhere.
  - Counter model reads 16 at the LOW->DONE decision and 0 after DONE.
- Start ignored: pulse start_i during HIGH of frame 1 -> no extra frame; one done_o.
- Back-to-back: start_i held high, miso patterns 0xFFFF then 0x0001 -> two done_o pulses 68 cycles apart, data_o = 0xFFFF then 0x0001, and cs_o high for exactly 2 cycles between frames (DONE + IDLE).
- Corner parameters: Bits=1, HalfDiv=1, miso_i=1 -> cs_o low 3 cycles, one sclk pulse, data_o=1, done_o 4 cycles after start.

Source files
------------

// File: rtl/spi_read_ctrl.sv
// -----------------------------------------------------------------------------
// spi_read_ctrl
//
// Sequencer for one SPI read frame (mode 0: CPOL=0, CPHA=0, MSB first).
// It owns chip select and the serial clock, shifts in miso_i once per sclk
// rising edge, and steers an external bit counter through a 2-bit opcode.
// The frame ends when the counter returned on cnt_i reaches Bits.
//
// Parameters
//   Width   : width of the external bit counter (Bits < 2**Width)
//   Bits    : bits per frame (1 .. 2**Width-1)
//   HalfDiv : sclk half-period in clk_i cycles (>= 1)
//
// Ports
//   clk_i    in   system clock, all state on the rising edge
//   rst_i    in   asynchronous reset, active high
//   start_i  in   frame request, only looked at in IDLE
//   miso_i   in   serial data from the slave
//   cnt_i    in   current value of the external bit counter
//   opc_o    out  counter opcode: 00 clear, 01 hold, 10 increment, 11 clear
//   cs_o     out  chip select, active low
//   sclk_o   out  serial clock, idles low
//   data_o   out  last completed frame, MSB = first bit received
//   busy_o   out  high from SETUP through the last LOW cycle
//   done_o   out  one-cycle pulse in the cycle data_o takes a new frame
//
// Handshake: start_i is a level request. It is sampled only while the
// sequencer is idle; a request seen outside IDLE is dropped, never queued.
// Holding start_i high yields back-to-back frames separated by one IDLE
// cycle. done_o pulses for exactly one cycle per completed frame, and data_o
// is stable from that cycle until the next done_o pulse.
// -----------------------------------------------------------------------------
module spi_read_ctrl #(
  parameter int Width   = 6,
  parameter int Bits    = 16,
  parameter int HalfDiv = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             miso_i,
  input  logic [Width-1:0] cnt_i,
  output logic [1:0]       opc_o,
  output logic             cs_o,
  output logic             sclk_o,
  output logic [Bits-1:0]  data_o,
  output logic             busy_o,
  output logic             done_o
);

  // Timer counts 0 .. HalfDiv-1 inside each timed state.
  localparam int TW = (HalfDiv > 1) ? $clog2(HalfDiv) : 1;
  localparam logic [TW-1:0]    T_LAST  = TW'(HalfDiv - 1);
  localparam logic [Width-1:0] CNT_END = Width'(Bits);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_HIGH  = 3'd2;
  localparam logic [2:0] S_LOW   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] OPC_CLEAR = 2'b00;
  localparam logic [1:0] OPC_HOLD  = 2'b01;
  localparam logic [1:0] OPC_INC   = 2'b10;

  logic [2:0]      state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [Bits-1:0] shift_q, shift_d, shift_next;
  logic            timer_last;
  logic            sample_bit;

  logic            cs_d;
  logic            sclk_d;
  logic [1:0]      opc_d;
  logic            busy_d;
  logic            done_d;
  logic [Bits-1:0] data_d;

  assign timer_last = (timer_q == T_LAST);

  // The bit is captured on the first HIGH cycle, i.e. right after sclk rose.
  assign sample_bit = (state_q == S_HIGH) && (timer_q == '0);

  // A one-bit frame has nothing to shift through; the sample is the frame.
  generate
    if (Bits == 1) begin : g_shift_one
      assign shift_next = miso_i;
    end else begin : g_shift_many
      assign shift_next = {shift_q[Bits-2:0], miso_i};
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next state and timer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (start_i) begin
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (timer_last) begin
          state_d = S_HIGH;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_HIGH: begin
        if (timer_last) begin
          state_d = S_LOW;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_LOW: begin
        // The increment issued on the first HIGH cycle has landed in the
        // counter long before the last LOW cycle, so cnt_i is current here.
        if (timer_last) begin
          timer_d = '0;
          state_d = (cnt_i == CNT_END) ? S_DONE : S_HIGH;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode. Outputs are registered, so they are decoded from the
  // upcoming state/timer; after the clock edge each output equals the decode
  // of the state/timer it is presented alongside.
  // ---------------------------------------------------------------------------
  always_comb begin
    cs_d   = 1'b1;
    sclk_d = 1'b0;
    opc_d  = OPC_CLEAR;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      S_IDLE: begin
        opc_d = OPC_CLEAR;
      end
      S_SETUP: begin
        cs_d   = 1'b0;
        opc_d  = OPC_HOLD;
        busy_d = 1'b1;
      end
      S_HIGH: begin
        cs_d   = 1'b0;
        sclk_d = 1'b1;
        busy_d = 1'b1;
        // Exactly one increment per sclk rising edge.
        opc_d  = (timer_d == '0) ? OPC_INC : OPC_HOLD;
      end
      S_LOW: begin
        cs_d   = 1'b0;
        opc_d  = OPC_HOLD;
        busy_d = 1'b1;
      end
      S_DONE: begin
        opc_d  = OPC_CLEAR;
        done_d = 1'b1;
      end
      default: begin
        opc_d = OPC_CLEAR;
      end
    endcase
  end

  assign shift_d = sample_bit ? shift_next : shift_q;

  // data_o only moves on the way into DONE, so it is untouched mid-frame.
  assign data_d = (state_d == S_DONE) ? shift_q : data_o;

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      shift_q <= '0;
      cs_o    <= 1'b1;
      sclk_o  <= 1'b0;
      opc_o   <= OPC_CLEAR;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      data_o  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      shift_q <= shift_d;
      cs_o    <= cs_d;
      sclk_o  <= sclk_d;
      opc_o   <= opc_d;
      busy_o  <= busy_d;
      done_o  <= done_d;
      data_o  <= data_d;
    end
  end

endmodule
